// File: rtl/uart_frame_writer.sv
// UART byte stream to framebuffer loader: sync-framed, two 3-bit pixels per byte.
// Optional idle abort in LOAD/PIX1 is compiled in with UART_FRAME_WRITER_TIMEOUT_EN.
module uart_frame_writer #(
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned ADDR_W         = 19,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        ram_data,
    output logic              ram_we,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPix1} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [2:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [2:0]        ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic              fin_q, fin_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [1:0]        err_add;
    logic [8:0]        err_sum;
    logic              in_vld;
    logic [7:0]        in_byte;
    logic [ADDR_W-1:0] ptr_odd;

`ifdef UART_FRAME_WRITER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // A held byte takes priority over a fresh strobe; both at once loses the new one.
    assign in_vld  = hold_vld_q | rx_done;
    assign in_byte = hold_vld_q ? hold_q : rx_data;
    assign ptr_odd = ptr_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hi_d       = hi_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        fin_d      = 1'b0;
        err_add    = 2'd0;

        unique case (state_q)
            StIdle, StLoad: begin
                if (hold_vld_q) begin
                    hold_vld_d = 1'b0;
                    if (rx_done) err_add = err_add + 2'd1;
                end
                if (in_vld) begin
                    if (in_byte == SYNC_BYTE) begin
                        ptr_d   = '0;
                        state_d = StLoad;
                        if (state_q == StLoad) err_add = err_add + 2'd1;
                    end else if (state_q == StIdle) begin
                        // non-sync bytes outside a frame are ignored
                    end else if (in_byte[3] || in_byte[7]) begin
                        err_add = err_add + 2'd1;
                    end else begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = ptr_q;
                        ram_data_d = in_byte[2:0];
                        if (ptr_q == LAST_ADDR) begin
                            ptr_d   = '0;
                            fin_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            hi_d    = in_byte[6:4];
                            state_d = StPix1;
                        end
                    end
                end
            end
            StPix1: begin
                ram_we_d   = 1'b1;
                ram_addr_d = ptr_odd;
                ram_data_d = hi_q;
                if (ptr_odd == LAST_ADDR) begin
                    ptr_d   = '0;
                    fin_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(2);
                    state_d = StLoad;
                end
                if (rx_done) begin
                    if (hold_vld_q) begin
                        err_add = err_add + 2'd1;
                    end else begin
                        hold_d     = rx_data;
                        hold_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef UART_FRAME_WRITER_TIMEOUT_EN
        tmo_cnt_d = (state_q == StIdle || rx_done) ? '0 : tmo_cnt_q + TmoW'(1);
        if (state_q != StIdle && !rx_done && tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_d  = '0;
            state_d    = StIdle;
            ptr_d      = '0;
            hold_vld_d = 1'b0;
            ram_we_d   = 1'b0;
            fin_d      = 1'b0;
            err_add    = err_add + 2'd1;
        end
`endif

        // busy stays up through the final write and drops with frame_done
        busy_d       = (state_d != StIdle) | fin_d;
        frame_done_d = fin_q;
        err_sum      = {1'b0, err_cnt_q} + {7'd0, err_add};
        err_cnt_d    = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            hi_q         <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            fin_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_cnt_q    <= '0;
`ifdef UART_FRAME_WRITER_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            hi_q         <= hi_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_we_q     <= ram_we_d;
            fin_q        <= fin_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_cnt_q    <= err_cnt_d;
`ifdef UART_FRAME_WRITER_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_we     = ram_we_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer on a 4x2 frame: per-cycle vector table plus
// hand sequences for reset-in-PIX1 and the idle timeout.
module tb_uart_frame_writer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [2:0]    ram_data;
    logic          ram_we;
    logic          frame_done;
    logic          busy;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    uart_frame_writer #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .ADDR_W         (AW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .frame_done (frame_done),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    // one row = byte driven this cycle, outputs expected in the following cycle
    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       we;
        logic [2:0] addr;
        logic [2:0] wdata;
        logic       fd;
        logic       busy;
        logic [7:0] err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic d, logic [7:0] b, logic we, logic [2:0] a, logic [2:0] wd,
                                logic fd, logic bz, logic [7:0] e);
        vec_t v;
        v.done = d; v.data = b; v.we = we; v.addr = a; v.wdata = wd;
        v.fd = fd; v.busy = bz; v.err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {ram_we, ram_addr, ram_data, frame_done, busy, err_cnt};
    endfunction

    initial begin
        //               done data   we a  d  fd bz err
        vecs[0]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);  // reset state
        vecs[1]  = mk(1, 8'h21, 0, 0, 0, 0, 0, 0);  // ignored in IDLE
        vecs[2]  = mk(1, 8'hA5, 0, 0, 0, 0, 1, 0);  // sync
        vecs[3]  = mk(1, 8'h21, 1, 0, 1, 0, 1, 0);
        vecs[4]  = mk(0, 8'h00, 1, 1, 2, 0, 1, 0);
        vecs[5]  = mk(1, 8'h88, 0, 1, 2, 0, 1, 1);  // bad byte
        vecs[6]  = mk(1, 8'hA5, 0, 1, 2, 0, 1, 2);  // sync mid-frame
        vecs[7]  = mk(1, 8'h07, 1, 0, 7, 0, 1, 2);
        vecs[8]  = mk(1, 8'h53, 1, 1, 0, 0, 1, 2);  // back-to-back, held
        vecs[9]  = mk(0, 8'h00, 1, 2, 3, 0, 1, 2);
        vecs[10] = mk(0, 8'h00, 1, 3, 5, 0, 1, 2);
        vecs[11] = mk(1, 8'h12, 1, 4, 2, 0, 1, 2);  // three in a row
        vecs[12] = mk(1, 8'h34, 1, 5, 1, 0, 1, 2);
        vecs[13] = mk(1, 8'h66, 1, 6, 4, 0, 1, 3);  // third dropped
        vecs[14] = mk(0, 8'h00, 1, 7, 3, 0, 1, 3);  // last pixel
        vecs[15] = mk(0, 8'h00, 0, 7, 3, 1, 0, 3);  // frame_done
        vecs[16] = mk(0, 8'h00, 0, 7, 3, 0, 0, 3);
        vecs[17] = mk(1, 8'hA5, 0, 7, 3, 0, 1, 3);  // new frame
        vecs[18] = mk(1, 8'h10, 1, 0, 0, 0, 1, 3);
        vecs[19] = mk(0, 8'h00, 1, 1, 1, 0, 1, 3);
        vecs[20] = mk(1, 8'h08, 0, 1, 1, 0, 1, 4);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rx_done = vecs[i].done;
            rx_data = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d{we,addr,data,fd,busy,err}", i), 32'(outs()),
                  32'({vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].fd, vecs[i].busy,
                       vecs[i].err}));
        end

        // reset while in PIX1 (pointer is 2 here)
        rx_done = 1'b1;
        rx_data = 8'h44;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        @(posedge clk);
        #1;
        check("pix1_write_before_reset", 32'({ram_we, ram_addr, ram_data}), 32'({1'b1, 3'd3, 3'd4}));
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_done = 1'b1;
            rx_data = 8'h21 + 8'(i);
            @(negedge clk);
            check($sformatf("post_reset_idle%0d{we,busy}", i), 32'({ram_we, busy}), 32'd0);
        end
        rx_done = 1'b0;

        // silence after sync
        rx_done = 1'b1;
        rx_data = 8'hA5;
        @(negedge clk);
        rx_done = 1'b0;
        check("busy_after_sync", 32'(busy), 32'd1);
        repeat (150) @(negedge clk);
`ifdef UART_FRAME_WRITER_TIMEOUT_EN
        check("timeout{busy,err}", 32'({busy, err_cnt}), 32'({1'b0, 8'd1}));
`else
        check("no_timeout{busy,err}", 32'({busy, err_cnt}), 32'({1'b1, 8'd0}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
